tt_um_jimktrains_vslc_sequencer: RTL and testbench

Program sequencer directly upstream of the VSLC executor. It holds the ladder program in a small byte memory loaded over a byte-stream port. In run mode it executes repeated scan cycles. Each scan latches a consistent input image, keeps the previous scan's image for edge detection, and issues the program to the executor as `instr` plus one-cycle `instr_ready` strobes.

---
 rtl/vslc_pkg.sv | 32 +++
 rtl/tt_um_jimktrains_vslc_progmem.sv | 32 +++
 rtl/tt_um_jimktrains_vslc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tt_um_jimktrains_vslc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vslc_pkg                                                             |
// | Shared types and constants for the VSLC program sequencer.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vslc_pkg;

   // Sequencer control states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SNAP  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   // Unused executor opcode, reserved as the end-of-program marker
   localparam logic [7:0] VSLC_OP_END = 8'hFF;

   // Executor instruction fields: opcode in the upper bits, operand below
   localparam int VSLC_OPC_MSB = 7;
   localparam int VSLC_OPC_LSB = 3;
   localparam int VSLC_ARG_MSB = 2;
   localparam int VSLC_ARG_LSB = 0;

   function automatic logic is_end(input logic [7:0] b);
      return b == VSLC_OP_END;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_um_jimktrains_vslc_progmem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_um_jimktrains_vslc_progmem                                        |
// | PROG_DEPTH x 8 program store, synchronous write, asynchronous read.  |
// | Contents are not reset; the sequencer owns all pointers.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tt_um_jimktrains_vslc_progmem #(
   parameter int PROG_DEPTH = 16,
   parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [PROG_DEPTH];

   // Byte write from the load port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_um_jimktrains_vslc_sequencer                                      |
// | Loads a ladder program over a byte stream and replays it to the      |
// | VSLC executor in repeated scans, with a per-scan input snapshot.     |
// | Optional feature macro: VSLC_SEQ_SINGLE_STEP_EN (step_en/step ports) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tt_um_jimktrains_vslc_sequencer
   import vslc_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
`ifdef VSLC_SEQ_SINGLE_STEP_EN
   input  logic              step_en,
   input  logic              step,
`endif
   output logic              load_err,
   input  logic [7:0]        ui_in,
   output logic [7:0]        ui_snap,
   output logic [7:0]        ui_in_prev,
   output logic [7:0]        instr,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   prog_len,
   output logic              scan_done,
   output logic              busy
);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] raddr;
   logic [7:0]        rdata;
   logic              mem_we;
   logic              full;
   logic              last;
   logic              advance;
   logic              ready_q;

   assign full   = (prog_len == (ADDR_W+1)'(PROG_DEPTH));
   assign last   = ({1'b0, pc} == prog_len - (ADDR_W+1)'(1));
   assign mem_we = (state == ST_LOAD) && load_valid && !full;

`ifdef VSLC_SEQ_SINGLE_STEP_EN
   // In step mode the presented instruction only issues in a step cycle
   assign advance     = !step_en || step;
   assign instr_ready = ready_q && advance;
`else
   assign advance     = 1'b1;
   assign instr_ready = ready_q;
`endif

   tt_um_jimktrains_vslc_progmem #(
      .PROG_DEPTH (PROG_DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_progmem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr),
      .wdata (load_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; the read address looks one instruction ahead so instr is registered
   always_comb begin
      state_nxt = state;
      raddr     = pc + ADDR_W'(1);
      unique case (state)
         ST_IDLE: begin
            if (load_en) begin
               state_nxt = ST_LOAD;
            end else if (run && (prog_len != '0)) begin
               state_nxt = ST_SNAP;
            end
         end
         ST_LOAD: begin
            if (!load_en) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SNAP: begin
            raddr     = '0;
            state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (advance && (is_end(instr) || last)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = run ? ST_SNAP : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs, load pointers and input images
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr       <= '0;
         prog_len   <= '0;
         load_err   <= 1'b0;
         ui_snap    <= '0;
         ui_in_prev <= '0;
         instr      <= '0;
         ready_q    <= 1'b0;
         pc         <= '0;
         scan_done  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         scan_done <= (state_nxt == ST_DONE);
         busy      <= (state_nxt != ST_IDLE);
         unique case (state)
            ST_IDLE: begin
               ready_q <= 1'b0;
               if (load_en) begin
                  wptr     <= '0;
                  prog_len <= '0;
                  load_err <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_valid) begin
                  if (full) begin
                     load_err <= 1'b1;
                  end else begin
                     wptr     <= wptr + ADDR_W'(1);
                     prog_len <= prog_len + (ADDR_W+1)'(1);
                  end
               end
            end
            ST_SNAP: begin
               ui_in_prev <= ui_snap;
               ui_snap    <= ui_in;
               pc         <= '0;
               instr      <= rdata;
               ready_q    <= !is_end(rdata);
            end
            ST_ISSUE: begin
               if (advance) begin
                  if (state_nxt == ST_DONE) begin
                     ready_q <= 1'b0;
                  end else begin
                     pc      <= pc + ADDR_W'(1);
                     instr   <= rdata;
                     ready_q <= !is_end(rdata);
                  end
               end
            end
            default: ready_q <= 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tt_um_jimktrains_vslc_sequencer                                   |
// | Self-checking bench with a queue-based program/scan model.           |
// | Optional feature macro: VSLC_SEQ_SINGLE_STEP_EN                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tt_um_jimktrains_vslc_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst, run, load_en, load_valid;
   logic [7:0]    load_data, ui_in;
   logic          load_err, instr_ready, scan_done, busy;
   logic [7:0]    ui_snap, ui_in_prev, instr;
   logic [AW-1:0] pc;
   logic [AW:0]   prog_len;
`ifdef VSLC_SEQ_SINGLE_STEP_EN
   logic          step_en, step;
`endif

   int         total = 0;
   int         bad   = 0;
   logic [7:0] prog_q[$];
   logic [7:0] model_prev;

   always #5 clk = ~clk;

   tt_um_jimktrains_vslc_sequencer #(.PROG_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .load_en     (load_en),
      .load_valid  (load_valid),
      .load_data   (load_data),
`ifdef VSLC_SEQ_SINGLE_STEP_EN
      .step_en     (step_en),
      .step        (step),
`endif
      .load_err    (load_err),
      .ui_in       (ui_in),
      .ui_snap     (ui_snap),
      .ui_in_prev  (ui_in_prev),
      .instr       (instr),
      .instr_ready (instr_ready),
      .pc          (pc),
      .prog_len    (prog_len),
      .scan_done   (scan_done),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a byte stream; the last byte goes in the same cycle load_en drops
   task automatic load_prog(input logic [7:0] b[$], input string tag);
      int n;
      load_en = 1'b1;
      tick();
      for (int i = 0; i < b.size(); i++) begin
         load_valid = 1'b1;
         load_data  = b[i];
         if (i == b.size() - 1) load_en = 1'b0;
         tick();
      end
      if (b.size() == 0) begin
         load_en = 1'b0;
         tick();
      end
      load_valid = 1'b0;
      load_data  = 8'h00;
      prog_q = {};
      for (int i = 0; i < b.size() && i < DEPTH; i++) prog_q.push_back(b[i]);
      n = prog_q.size();
      chk({tag, "_prog_len"}, 32'(prog_len), n);
      chk({tag, "_load_err"}, 32'(load_err), 32'(b.size() > DEPTH));
      chk({tag, "_busy_idle"}, 32'(busy), 0);
   endtask

   // One scan starting from the cycle before SNAP; cycle 1 is the SNAP cycle
   task automatic scan_check(input logic [7:0] snap_val, input bit drop_run, input string tag);
      logic [7:0] exp_q[$];
      int n_issue, ns;
      bit done;
      n_issue = prog_q.size();
      ns   = 0;
      done = 1'b0;
      for (int i = 0; i < prog_q.size(); i++) begin
         if (prog_q[i] == 8'hFF) begin
            n_issue = i + 1;
            break;
         end
         exp_q.push_back(prog_q[i]);
      end
      for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
         tick();
         if (cyc == 1) begin
            chk({tag, "_busy_snap"}, 32'(busy), 1);
            ui_in = snap_val;
         end
         if (cyc == 2) begin
            ui_in = 8'($urandom);
            if (drop_run) run = 1'b0;
         end
         if (instr_ready) begin
            if (ns < exp_q.size()) begin
               chk({tag, "_instr"},   32'(instr), 32'(exp_q[ns]));
               chk({tag, "_pc"},      32'(pc), ns);
               chk({tag, "_when"},    cyc, 2 + ns);
               chk({tag, "_ui_snap"}, 32'(ui_snap), 32'(snap_val));
               chk({tag, "_ui_prev"}, 32'(ui_in_prev), 32'(model_prev));
            end else begin
               chk({tag, "_extra_strobe"}, 32'(instr_ready), 0);
            end
            ns++;
         end
         if (scan_done) begin
            chk({tag, "_done_cycle"}, cyc, 2 + n_issue);
            done = 1'b1;
         end
      end
      chk({tag, "_strobes"}, ns, exp_q.size());
      chk({tag, "_done_seen"}, 32'(done), 1);
      model_prev = snap_val;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   // Directed and randomized sequence
   initial begin
      logic [7:0] q[$];
      int         len, cnt;
      rst = 1'b1; run = 1'b0; load_en = 1'b0; load_valid = 1'b0;
      load_data = 8'h00; ui_in = 8'h00; model_prev = 8'h00;
`ifdef VSLC_SEQ_SINGLE_STEP_EN
      step_en = 1'b0; step = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", 32'(instr), 0);
      chk("rst_ready", 32'(instr_ready), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_len", 32'(prog_len), 0);
      chk("rst_snap", 32'(ui_snap), 0);
      chk("rst_prev", 32'(ui_in_prev), 0);
      chk("rst_err", 32'(load_err), 0);
      chk("rst_done", 32'(scan_done), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();

      // Empty program: run must not start a scan
      run = 1'b1;
      repeat (4) tick();
      chk("empty_busy", 32'(busy), 0);
      chk("empty_ready", 32'(instr_ready), 0);
      run = 1'b0;

      // Basic run with back-to-back scans and input history
      q = {8'h00, 8'h98, 8'h10};
      load_prog(q, "basic_load");
      run = 1'b1;
      scan_check(8'h01, 1'b0, "basic1");
      scan_check(8'h03, 1'b0, "basic2");
      run = 1'b0;
      tick();
      chk("basic_idle", 32'(busy), 0);

      // END marker, with run dropped mid-scan
      q = {8'h01, 8'hFF, 8'h02};
      load_prog(q, "end_load");
      run = 1'b1;
      scan_check(8'($urandom), 1'b1, "endm");
      tick();
      chk("endm_idle", 32'(busy), 0);

      // Randomized programs
      for (int r = 0; r < 5; r++) begin
         len = $urandom_range(1, DEPTH);
         q = {};
         for (int i = 0; i < len; i++)
            q.push_back(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
         load_prog(q, "rand_load");
         run = 1'b1;
         scan_check(8'($urandom), 1'b0, "rand_a");
         scan_check(8'($urandom), 1'b0, "rand_b");
         run = 1'b0;
         tick();
         chk("rand_idle", 32'(busy), 0);
      end

      // Overflow: 17 bytes, the 17th is dropped
      q = {};
      for (int i = 0; i < DEPTH + 1; i++) q.push_back(8'(i * 7 + 3));
      load_prog(q, "ovf_load");
      run = 1'b1;
      scan_check(8'h5A, 1'b1, "ovf");
      tick();

      // Reload clears load_err
      q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      load_prog(q, "reload");

      // Reset in the middle of a scan
      run = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("mrst_ready", 32'(instr_ready), 0);
      chk("mrst_pc", 32'(pc), 0);
      chk("mrst_instr", 32'(instr), 0);
      chk("mrst_len", 32'(prog_len), 0);
      chk("mrst_busy", 32'(busy), 0);
      #2;
      rst = 1'b0;
      model_prev = 8'h00;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (instr_ready) cnt++;
      end
      chk("mrst_no_strobe", cnt, 0);
      chk("mrst_busy_after", 32'(busy), 0);
      run = 1'b0;

`ifdef VSLC_SEQ_SINGLE_STEP_EN
      // Single step: three step pulses, each producing exactly one strobe
      q = {8'h21, 8'h42, 8'h63};
      load_prog(q, "step_load");
      step_en = 1'b1;
      run = 1'b1;
      tick();
      run = 1'b0;
      cnt = 0;
      for (int cyc = 2; cyc <= 16; cyc++) begin
         tick();
         step = (cyc % 4 == 0) && (cyc <= 12);
         #1;
         chk("step_strobe", 32'(instr_ready), 32'(step));
         if (instr_ready) cnt++;
      end
      step = 1'b0;
      step_en = 1'b0;
      chk("step_count", cnt, 3);
      chk("step_idle", 32'(busy), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
